// File: rtl/pred_update_sched.sv
// Commit-to-predictor update scheduler: takes up to two retiring outcomes per cycle
// and drains one per cycle. Optional single-entry bypass when built with PRED_UPD_BYPASS_EN.
module pred_update_sched #(
    parameter int QDEPTH = 8,
    parameter int QIDLEN = $clog2(QDEPTH),
    parameter int CNTLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid_0,
    input  logic              commit_valid_1,
    input  logic [31:0]       commit_pc_0,
    input  logic [31:0]       commit_pc_1,
    input  logic [2:0]        commit_type_0,
    input  logic [2:0]        commit_type_1,
    input  logic              commit_taken_0,
    input  logic              commit_taken_1,
    input  logic              commit_mistaken_0,
    input  logic              commit_mistaken_1,
    input  logic [31:0]       commit_target_0,
    input  logic [31:0]       commit_target_1,
    output logic              commit_ready,
    output logic              update_orien_en,
    output logic [31:0]       retire_pc,
    output logic              right_orien,
    output logic              branch_mistaken,
    output logic [31:0]       wrong_pc,
    output logic [31:0]       right_target,
    output logic [2:0]        ins_type_w,
    output logic [CNTLEN-1:0] mispred_cnt
);
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        taken;
        logic        mistaken;
        logic [31:0] target;
    } entry_t;

    entry_t            mem [QDEPTH];
    logic [QIDLEN-1:0] head, tail, tail_p1;
    logic [QIDLEN:0]   occ, occ_next;
    entry_t            slot0, slot1, first, ent_a, src;
    logic              acc0, acc1, pop, byp, wr_a, wr_b, fire;

    assign slot0 = '{commit_pc_0, commit_type_0, commit_taken_0, commit_mistaken_0, commit_target_0};
    assign slot1 = '{commit_pc_1, commit_type_1, commit_taken_1, commit_mistaken_1, commit_target_1};

    // Room for a whole pair is required, so a single free slot still stalls commit.
    assign commit_ready = occ <= (QIDLEN+1)'(QDEPTH - 2);

    assign acc0  = commit_valid_0 && commit_ready && (commit_type_0 != 3'b000 || commit_mistaken_0);
    assign acc1  = commit_valid_0 && commit_valid_1 && commit_ready &&
                   (commit_type_1 != 3'b000 || commit_mistaken_1);
    assign first = acc0 ? slot0 : slot1;
    assign pop   = occ != '0;

`ifdef PRED_UPD_BYPASS_EN
    assign byp = (occ == '0) && (acc0 || acc1);
`else
    assign byp = 1'b0;
`endif

    // A bypassed oldest entry leaves at most slot 1 to be written into the queue.
    always_comb begin
        ent_a = first;
        wr_a  = 1'b0;
        wr_b  = 1'b0;
        if (byp) begin
            ent_a = slot1;
            wr_a  = acc0 && acc1;
        end else begin
            wr_a  = acc0 || acc1;
            wr_b  = acc0 && acc1;
        end
    end

    assign tail_p1  = tail + QIDLEN'(1);
    assign occ_next = occ + (QIDLEN+1)'(wr_a) + (QIDLEN+1)'(wr_b) - (QIDLEN+1)'(pop);
    assign fire     = pop || byp;
    assign src      = pop ? mem[head] : first;

    always_ff @(posedge clk) begin
        if (wr_a) mem[tail]    <= ent_a;
        if (wr_b) mem[tail_p1] <= slot1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            occ             <= '0;
            update_orien_en <= 1'b0;
            branch_mistaken <= 1'b0;
            retire_pc       <= '0;
            right_orien     <= 1'b0;
            wrong_pc        <= '0;
            right_target    <= '0;
            ins_type_w      <= '0;
            mispred_cnt     <= '0;
        end else begin
            if (pop) head <= head + QIDLEN'(1);
            tail            <= tail + QIDLEN'(wr_a) + QIDLEN'(wr_b);
            occ             <= occ_next;
            update_orien_en <= fire && (src.typ == 3'b101);
            branch_mistaken <= fire && src.mistaken;
            if (fire) begin
                retire_pc    <= src.pc;
                wrong_pc     <= src.pc;
                right_orien  <= src.taken;
                right_target <= src.target;
                ins_type_w   <= src.typ;
            end
            if (fire && src.mistaken && !(&mispred_cnt))
                mispred_cnt <= mispred_cnt + CNTLEN'(1);
        end
    end
endmodule

// File: tb/tb_pred_update_sched.sv
// Scoreboard bench for pred_update_sched: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_pred_update_sched;
    localparam int QD = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        taken;
        logic        mist;
        logic [31:0] tgt;
    } slot_t;

    typedef struct packed {
        logic          orien;
        logic          rorien;
        logic          mist;
        logic [31:0]   pc;
        logic [31:0]   tgt;
        logic [2:0]    typ;
        logic [CW-1:0] cnt;
        logic          ready;
    } exp_t;

    logic clk, reset;
    logic v0, v1, tk0, tk1, m0, m1;
    logic [31:0] pc0, pc1, tg0, tg1;
    logic [2:0] ty0, ty1;
    logic commit_ready, update_orien_en, right_orien, branch_mistaken;
    logic [31:0] retire_pc, wrong_pc, right_target;
    logic [2:0] ins_type_w;
    logic [CW-1:0] mispred_cnt;

    pred_update_sched #(.QDEPTH(QD), .CNTLEN(CW)) dut (
        .clk(clk), .reset(reset),
        .commit_valid_0(v0), .commit_valid_1(v1),
        .commit_pc_0(pc0), .commit_pc_1(pc1),
        .commit_type_0(ty0), .commit_type_1(ty1),
        .commit_taken_0(tk0), .commit_taken_1(tk1),
        .commit_mistaken_0(m0), .commit_mistaken_1(m1),
        .commit_target_0(tg0), .commit_target_1(tg1),
        .commit_ready(commit_ready), .update_orien_en(update_orien_en),
        .retire_pc(retire_pc), .right_orien(right_orien),
        .branch_mistaken(branch_mistaken), .wrong_pc(wrong_pc),
        .right_target(right_target), .ins_type_w(ins_type_w),
        .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails = 0;
    slot_t q[$];
    exp_t  expq[$];
    exp_t  cur = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic slot_t mk(input logic v, input logic [31:0] pc, input logic [2:0] t,
                                 input logic tk, input logic m, input logic [31:0] tg);
        slot_t s;
        s = '{v, pc, t, tk, m, tg};
        return s;
    endfunction

    function automatic bit keep(input slot_t s);
        return s.v && (s.typ != 3'b000 || s.mist);
    endfunction

    function automatic bit mready();
        return (QD - q.size()) >= 2;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge and queue its prediction.
    task automatic step(input slot_t s0, input slot_t s1, input bit rst);
        slot_t acc[$];
        slot_t o;
        bit have;
        reset = rst;
        v0 = s0.v; pc0 = s0.pc; ty0 = s0.typ; tk0 = s0.taken; m0 = s0.mist; tg0 = s0.tgt;
        v1 = s1.v; pc1 = s1.pc; ty1 = s1.typ; tk1 = s1.taken; m1 = s1.mist; tg1 = s1.tgt;
        if (rst) begin
            q.delete();
            cur = '0;
            cur.ready = 1'b1;
        end else begin
            if (mready()) begin
                if (keep(s0)) acc.push_back(s0);
                if (s0.v && keep(s1)) acc.push_back(s1);
            end
            have = 0;
            o = '0;
            if (q.size() > 0) begin
                o = q.pop_front();
                have = 1;
            end
`ifdef PRED_UPD_BYPASS_EN
            else if (acc.size() > 0) begin
                o = acc.pop_front();
                have = 1;
            end
`endif
            foreach (acc[i]) q.push_back(acc[i]);
            cur.orien = have && (o.typ == 3'b101);
            cur.mist  = have && o.mist;
            if (have) begin
                cur.pc = o.pc; cur.tgt = o.tgt; cur.typ = o.typ; cur.rorien = o.taken;
                if (o.mist && cur.cnt != {CW{1'b1}}) cur.cnt = cur.cnt + 1'b1;
            end
            cur.ready = mready();
        end
        @(posedge clk);
        expq.push_back(cur);
        #1;
    endtask

    // Commit holds the same pair until the model says there is room, then presents it once.
    task automatic commit(input slot_t s0, input slot_t s1);
        int guard = 0;
        while (!mready() && guard < 50) begin
            step(s0, s1, 0);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            fails++;
            $display("FAIL hold_timeout: ready never returned");
        end
        step(s0, s1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("update_orien_en", {31'b0, update_orien_en}, {31'b0, e.orien});
                check("branch_mistaken", {31'b0, branch_mistaken}, {31'b0, e.mist});
                check("commit_ready", {31'b0, commit_ready}, {31'b0, e.ready});
                check("retire_pc", retire_pc, e.pc);
                check("wrong_pc", wrong_pc, e.pc);
                check("right_orien", {31'b0, right_orien}, {31'b0, e.rorien});
                check("right_target", right_target, e.tgt);
                check("ins_type_w", {29'b0, ins_type_w}, {29'b0, e.typ});
                check("mispred_cnt", {{(32-CW){1'b0}}, mispred_cnt}, {{(32-CW){1'b0}}, e.cnt});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        slot_t a, b;
        step('0, '0, 1);
        step('0, '0, 1);

        // single conditional, taken, correctly predicted
        commit(mk(1, 32'h1c000010, 3'b101, 1, 0, 32'h1c000020), '0);
        idle(3);

        // slot 0 filtered out, slot 1 indirect mispredict
        commit(mk(1, 32'h1c000100, 3'b000, 0, 0, 32'h0),
               mk(1, 32'h1c000104, 3'b100, 1, 1, 32'h1c008000));
        idle(3);

        // back-to-back conditional pairs: fills, stalls, wraps, drains in order
        for (int i = 0; i < 9; i++)
            commit(mk(1, 32'h1c001000 + 32'(i * 8), 3'b101, i[0], 0, 32'h1c002000),
                   mk(1, 32'h1c001004 + 32'(i * 8), 3'b101, ~i[0], 0, 32'h1c003000));
        idle(12);

        // reset with a partially filled queue
        for (int i = 0; i < 4; i++)
            commit(mk(1, 32'h1c004000 + 32'(i * 8), 3'b101, 1, 1, 32'h1c005000),
                   mk(1, 32'h1c004004 + 32'(i * 8), 3'b010, 1, 0, 32'h1c006000));
        step('0, '0, 1);
        idle(10);

        // sustained mispredicts drive the narrow counter into saturation
        for (int i = 0; i < 20; i++)
            commit(mk(1, 32'h1c007000 + 32'(i * 4), 3'b001, 1, 1, 32'h1c00a000 + 32'(i)), '0);
        idle(5);

        // randomized traffic
        step('0, '0, 1);
        for (int i = 0; i < 400; i++) begin
            a = mk(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
            b = mk(a.v && ($urandom_range(0, 1) == 1), $urandom, 3'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 7) == 0) step('0, '0, 0);
            else commit(a, b);
        end
        idle(12);

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/pred_update_sched.md
Name: pred_update_sched

Overview:
- Scheduler between the dual-commit stage and the branch predictor's single update port.
- Accepts up to two retiring control-flow outcomes per cycle and buffers them in an in-order FIFO.
- Drains one entry per cycle into the predictor's orientation-update and mispredict-update inputs.
- Applies backpressure to commit when the FIFO cannot absorb a full commit pair.

Parameters:
- QDEPTH, 8, FIFO entries; power of two, at least 4.
- QIDLEN, $clog2(QDEPTH), FIFO pointer width.
- CNTLEN, 32, width of the mispredict statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid_0  in  1  slot-0 retiring instruction valid
- commit_valid_1  in  1  slot-1 valid; only meaningful when commit_valid_0=1
- commit_pc_0 / commit_pc_1  in  32  retiring pc
- commit_type_0 / commit_type_1  in  3  type: 000 none, 001 direct, 010 call, 011 ret, 100 indirect, 101 conditional
- commit_taken_0 / commit_taken_1  in  1  resolved direction
- commit_mistaken_0 / commit_mistaken_1  in  1  prediction was wrong
- commit_target_0 / commit_target_1  in  32  resolved target
- commit_ready  out  1  FIFO can accept a full pair this cycle
- update_orien_en  out  1  orientation update strobe to predictor
- retire_pc  out  32  pc for orientation update
- right_orien  out  1  resolved direction
- branch_mistaken  out  1  target/type repair strobe
- wrong_pc  out  32  mispredicted pc
- right_target  out  32  corrected target
- ins_type_w  out  3  type of mispredicted instruction
- mispred_cnt  out  CNTLEN  saturating count of mispredicts dequeued

Behaviour:
- Reset: FIFO empty, both pointers 0, occupancy 0, mispred_cnt 0, all update outputs 0, commit_ready 1.
- commit_ready = (QDEPTH - occupancy) >= 2. Computed from registered occupancy only; no dependence on the same-cycle dequeue.
- Enqueue filter: a slot is accepted when valid && commit_ready && (type != 000 || mistaken). Otherwise the slot is dropped silently.
- Commit holds its inputs while commit_ready=0.
- Accepted slots are written in order, slot 0 then slot 1. Zero, one or two writes per cycle; the tail advances by the number written.
- Dequeue: when occupancy > 0, the head is popped every cycle. No downstream stall exists.
- Update outputs are registered, loaded from the head at the pop edge and valid for one cycle.
- Latency: an entry enqueued at edge T is presented on the update outputs during the cycle after edge T+1 when the FIFO was empty.
- Output decode for the popped entry:
  - update_orien_en = (type == 101).
  - branch_mistaken = mistaken.
  - retire_pc = wrong_pc = pc.
  - right_orien = taken.
  - right_target = target.
  - ins_type_w = type.
- When nothing is popped, both strobes are 0. Data outputs hold their last value.
- Simultaneous two enqueues + one pop: occupancy += 1. One enqueue + one pop: unchanged.
- Wrap-around: pointers are QIDLEN bits and wrap modulo QDEPTH. Occupancy is a separate QIDLEN+1-bit register.
- Full: occupancy never exceeds QDEPTH. With QDEPTH-1 entries, commit_ready=0 even if one slot is free.
- mispred_cnt increments when a popped entry has mistaken=1, and saturates at all-ones.
- Reset mid-operation: all queued entries are discarded and strobes are low in the next cycle. No partial update is ever emitted.

Optional Feature:
- Macro PRED_UPD_BYPASS_EN.
- With the macro defined: when occupancy == 0 and exactly one slot is accepted, that entry goes straight to the output registers at the same edge and skips the FIFO. This gives 1-cycle latency.
  - When two slots are accepted into an empty FIFO, slot 0 bypasses and slot 1 is enqueued.
- Without the macro: every entry passes through the FIFO (2-cycle latency as above).

Test Plan:
- Reset, then a single conditional commit (pc=0x1c000010, type 101, taken=1, mistaken=0) → exactly one cycle later (two cycles without the macro) update_orien_en=1, retire_pc=0x1c000010, right_orien=1, branch_mistaken=0.
- Slot 0 type 000 not mistaken + slot 1 indirect (pc=0x1c000104, mistaken=1, target=0x1c008000) → only slot 1 is emitted: branch_mistaken=1, ins_type_w=100, right_target=0x1c008000, update_orien_en=0; mispred_cnt becomes 1.
- Commit pairs of conditional branches every cycle → occupancy rises by 1 per cycle; commit_ready drops at occupancy 7 (QDEPTH=8). After holding, all 14+ entries drain in exact pc order with no loss or duplicates across pointer wrap.
- Assert reset with 5 entries queued → the next cycle both strobes are 0, commit_ready=1, mispred_cnt=0, and no stale entry appears afterwards.
- Sustained one mistaken commit per cycle with CNTLEN overridden to 4 → mispred_cnt reaches 15 and stays at 15.
- Both slots valid while commit_ready=0 → no enqueue and occupancy unchanged; the entries are accepted once commit_ready returns to 1.
